// File: rtl/ot_pkg.sv
// Shared types and helpers for the ot_* output path: packed word payload,
// slots-per-word helper, default pad value and packer FSM states.
package ot_pkg;

   localparam int unsigned OT_IN_W  = 8;
   localparam int unsigned OT_OUT_W = 64;

   localparam logic [OT_IN_W-1:0] OT_PAD_DEF = '0;

   function automatic int unsigned ot_bpw(input int unsigned out_w, input int unsigned in_w);
      return out_w / in_w;
   endfunction

   localparam int unsigned OT_BPW = ot_bpw(OT_OUT_W, OT_IN_W);

   typedef struct packed {
      logic [OT_OUT_W-1:0] data;
      logic [OT_BPW-1:0]   keep;
      logic                last;
   } ot_word_t;

   typedef enum logic [0:0] {
      ST_ACC   = 1'b0,
      ST_STALL = 1'b1
   } ot_qpack_state_t;

endpackage

// File: rtl/ot_wfifo.sv
// Synchronous FIFO of packed words with level reporting; a push into a full
// FIFO is ignored, so upstream must honour the level (backpressure).
module ot_wfifo
   import ot_pkg::*;
#(
   parameter type         T     = ot_word_t,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  T                           i_data,
   input  logic                       i_pop,
   output T                           o_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic [$clog2(DEPTH+1)-1:0] o_level_nxt_c
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   T                 r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [LVL_W-1:0] r_level;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && (r_level != LVL_W'(DEPTH));
   assign w_pop  = i_pop && (r_level != '0);

   always_comb begin
      o_level_nxt_c = r_level;
      if (w_push && !w_pop) begin
         o_level_nxt_c = r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
         o_level_nxt_c = r_level - LVL_W'(1);
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         r_level <= o_level_nxt_c;
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

endmodule

// File: rtl/ot_qpack.sv
// Quantised-value packer: gathers IN_LANES values per beat into OUT_W-bit words
// and queues them for downstream. Optional counters under OT_QPACK_STAT_EN.
module ot_qpack
   import ot_pkg::*;
#(
   parameter int unsigned        IN_W      = OT_IN_W,
   parameter int unsigned        IN_LANES  = 1,
   parameter int unsigned        OUT_W     = OT_OUT_W,
   parameter int unsigned        OUT_DEPTH = 4,
   parameter logic [IN_W-1:0]    PAD_VAL   = IN_W'(OT_PAD_DEF)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                q_valid,
   output logic                                q_ready,
   input  logic [IN_LANES*IN_W-1:0]            q_data,
   input  logic                                q_last,
   output logic                                o_valid,
   input  logic                                o_ready,
   output logic [OUT_W-1:0]                    o_data,
   output logic [ot_bpw(OUT_W, IN_W)-1:0]      o_keep,
   output logic                                o_last,
   output logic [$clog2(OUT_DEPTH+1)-1:0]      o_level
`ifdef OT_QPACK_STAT_EN
   ,
   output logic [31:0]                         stat_words,
   output logic [15:0]                         stat_parts
`endif
);

   localparam int unsigned BPW   = ot_bpw(OUT_W, IN_W);
   localparam int unsigned NG    = BPW / IN_LANES;
   localparam int unsigned G_W   = (NG > 1) ? $clog2(NG) : 1;
   localparam int unsigned LW    = IN_LANES * IN_W;
   localparam int unsigned LVL_W = $clog2(OUT_DEPTH + 1);

   if (((BPW % IN_LANES) != 0) || ((OUT_W % IN_W) != 0)) begin : g_cfg_err
      $error("ot_qpack: IN_W must divide OUT_W and IN_LANES must divide OUT_W/IN_W");
   end

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [BPW-1:0]   keep;
      logic             last;
   } word_t;

   ot_qpack_state_t  r_state;
   ot_qpack_state_t  w_state_nxt;
   logic             r_q_ready;
   logic [G_W-1:0]   r_grp;
   logic [OUT_W-1:0] r_acc_data;
   logic [BPW-1:0]   r_acc_keep;
   logic [OUT_W-1:0] w_ins_data;
   logic [BPW-1:0]   w_ins_keep;
   logic             w_accept;
   logic             w_full_word;
   logic             w_commit;
   logic             w_pop;
   logic             w_empty;
   word_t            w_push_word;
   word_t            w_head;
   logic [LVL_W-1:0] w_level_nxt;

   // ptr is always a multiple of IN_LANES, so track it as a lane-group index.
   assign w_accept    = q_valid && r_q_ready;
   assign w_full_word = (r_grp == G_W'(NG - 1));
   assign w_commit    = w_accept && (w_full_word || q_last);

   always_comb begin
      w_ins_data = r_acc_data;
      w_ins_keep = r_acc_keep;
      for (int g = 0; g < int'(NG); g++) begin
         if (r_grp == G_W'(g)) begin
            w_ins_data[g*LW +: LW]             = q_data;
            w_ins_keep[g*IN_LANES +: IN_LANES] = '1;
         end
      end
   end

   // Unwritten slots of a flushed word carry PAD_VAL.
   always_comb begin
      w_push_word = '0;
      for (int s = 0; s < int'(BPW); s++) begin
         w_push_word.data[s*IN_W +: IN_W] = w_ins_keep[s] ? w_ins_data[s*IN_W +: IN_W] : PAD_VAL;
      end
      w_push_word.keep = w_ins_keep;
      w_push_word.last = q_last;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grp      <= '0;
         r_acc_data <= '0;
         r_acc_keep <= '0;
      end else if (w_accept) begin
         if (w_commit) begin
            r_grp      <= '0;
            r_acc_keep <= '0;
         end else begin
            r_grp      <= r_grp + G_W'(1);
            r_acc_data <= w_ins_data;
            r_acc_keep <= w_ins_keep;
         end
      end
   end

   ot_wfifo #(
      .T     (word_t),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .i_push        (w_commit),
      .i_data        (w_push_word),
      .i_pop         (w_pop),
      .o_data        (w_head),
      .o_empty       (w_empty),
      .o_level       (o_level),
      .o_level_nxt_c (w_level_nxt)
   );

   assign o_valid = !w_empty;
   assign w_pop   = o_valid && o_ready;
   assign o_data  = w_head.data;
   assign o_keep  = w_head.keep;
   assign o_last  = w_head.last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:   if (w_level_nxt == LVL_W'(OUT_DEPTH)) w_state_nxt = ST_STALL;
         ST_STALL: if (w_level_nxt < LVL_W'(OUT_DEPTH))  w_state_nxt = ST_ACC;
         default:  w_state_nxt = ST_ACC;
      endcase
   end

   // q_ready follows the next state so it reflects the occupancy it is paired with.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_ACC;
         r_q_ready <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_q_ready <= (w_state_nxt == ST_ACC);
      end
   end

   assign q_ready = r_q_ready;

`ifdef OT_QPACK_STAT_EN
   logic [31:0] r_stat_words;
   logic [15:0] r_stat_parts;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_words <= '0;
         r_stat_parts <= '0;
      end else if (w_pop) begin
         if (r_stat_words != '1) r_stat_words <= r_stat_words + 32'(1);
         if ((w_head.keep != '1) && (r_stat_parts != '1)) r_stat_parts <= r_stat_parts + 16'(1);
      end
   end

   assign stat_words = r_stat_words;
   assign stat_parts = r_stat_parts;
`endif

endmodule

// File: tb/tb_ot_qpack.sv
// Directed bench for ot_qpack: default 1-lane instance plus a 4-lane instance.
module tb_ot_qpack;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        q_valid = 1'b0;
   logic        q_ready;
   logic [7:0]  q_data = '0;
   logic        q_last = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b1;
   logic [63:0] o_data;
   logic [7:0]  o_keep;
   logic        o_last;
   logic [2:0]  o_level;

   logic        q4_valid = 1'b0;
   logic        q4_ready;
   logic [31:0] q4_data = '0;
   logic        q4_last = 1'b0;
   logic        o4_valid;
   logic        o4_ready = 1'b1;
   logic [63:0] o4_data;
   logic [7:0]  o4_keep;
   logic        o4_last;
   logic [2:0]  o4_level;

`ifdef OT_QPACK_STAT_EN
   logic [31:0] stat_words, stat4_words;
   logic [15:0] stat_parts, stat4_parts;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] pop_q[$];
   logic        mon_en = 1'b0;
   logic [63:0] exp_w;

   always #5 clk = ~clk;

   ot_qpack u_dut (
      .clk     (clk),
      .reset   (reset),
      .q_valid (q_valid),
      .q_ready (q_ready),
      .q_data  (q_data),
      .q_last  (q_last),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_keep  (o_keep),
      .o_last  (o_last),
      .o_level (o_level)
`ifdef OT_QPACK_STAT_EN
      ,
      .stat_words (stat_words),
      .stat_parts (stat_parts)
`endif
   );

   ot_qpack #(.IN_LANES(4)) u_dut4 (
      .clk     (clk),
      .reset   (reset),
      .q_valid (q4_valid),
      .q_ready (q4_ready),
      .q_data  (q4_data),
      .q_last  (q4_last),
      .o_valid (o4_valid),
      .o_ready (o4_ready),
      .o_data  (o4_data),
      .o_keep  (o4_keep),
      .o_last  (o4_last),
      .o_level (o4_level)
`ifdef OT_QPACK_STAT_EN
      ,
      .stat_words (stat4_words),
      .stat_parts (stat4_parts)
`endif
   );

   always @(negedge clk) begin
      if (mon_en && o_valid && o_ready) pop_q.push_back(o_data);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [7:0] d, input logic l);
      int n = 0;
      q_valid = 1'b1;
      q_data  = d;
      q_last  = l;
      while (!q_ready && n < 200) begin
         tick();
         n++;
      end
      if (!q_ready) chk("send1_ready_timeout", 64'(q_ready), 64'd1);
      tick();
      q_valid = 1'b0;
      q_last  = 1'b0;
   endtask

   task automatic send4(input logic [31:0] d, input logic l);
      int n = 0;
      q4_valid = 1'b1;
      q4_data  = d;
      q4_last  = l;
      while (!q4_ready && n < 200) begin
         tick();
         n++;
      end
      if (!q4_ready) chk("send4_ready_timeout", 64'(q4_ready), 64'd1);
      tick();
      q4_valid = 1'b0;
      q4_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_q_ready", 64'(q_ready), 64'd0);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_o_data",  o_data,       64'd0);
      chk("rst_o_keep",  64'(o_keep),  64'd0);
      chk("rst_o_last",  64'(o_last),  64'd0);
      chk("rst_o_level", 64'(o_level), 64'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_q_ready", 64'(q_ready), 64'd1);

      // Full word of 8 single-byte beats
      for (int i = 1; i <= 7; i++) send1(8'(i), 1'b0);
      chk("s1_no_valid_before_8th", 64'(o_valid), 64'd0);
      send1(8'h08, 1'b0);
      chk("s1_valid", 64'(o_valid), 64'd1);
      chk("s1_data",  o_data, 64'h0807060504030201);
      chk("s1_keep",  64'(o_keep), 64'hFF);
      chk("s1_last",  64'(o_last), 64'd0);

      // Partial word flushed by q_last
      send1(8'hAA, 1'b0);
      send1(8'hBB, 1'b0);
      send1(8'hCC, 1'b1);
      chk("s2_valid", 64'(o_valid), 64'd1);
      chk("s2_data",  o_data, 64'h0000000000CCBBAA);
      chk("s2_keep",  64'(o_keep), 64'h07);
      chk("s2_last",  64'(o_last), 64'd1);
      tick();
      chk("s2_level_after_pop", 64'(o_level), 64'd0);
`ifdef OT_QPACK_STAT_EN
      chk("stat_words", 64'(stat_words), 64'd2);
      chk("stat_parts", 64'(stat_parts), 64'd1);
`endif
      send1(8'h11, 1'b1);
      chk("s2_slot0_data", o_data, 64'h0000000000000011);
      chk("s2_slot0_keep", 64'(o_keep), 64'h01);
      chk("s2_slot0_last", 64'(o_last), 64'd1);
      tick();

      // Four lanes per beat
      send4(32'h44332211, 1'b0);
      chk("s3_no_valid_mid", 64'(o4_valid), 64'd0);
      send4(32'h88776655, 1'b1);
      chk("s3_valid", 64'(o4_valid), 64'd1);
      chk("s3_data",  o4_data, 64'h8877665544332211);
      chk("s3_keep",  64'(o4_keep), 64'hFF);
      chk("s3_last",  64'(o4_last), 64'd1);
      tick();

      // Backpressure: fill the FIFO, then drain five words in order
      o_ready = 1'b0;
      for (int i = 0; i < 32; i++) send1(8'(i + 1), 1'b0);
      chk("s4_q_ready_full", 64'(q_ready), 64'd0);
      chk("s4_level_full",   64'(o_level), 64'd4);
      pop_q.delete();
      mon_en  = 1'b1;
      o_ready = 1'b1;
      for (int i = 32; i < 40; i++) send1(8'(i + 1), 1'b0);
      begin
         int n = 0;
         while (o_level != 3'd0 && n < 50) begin
            tick();
            n++;
         end
      end
      chk("s4_level_drained", 64'(o_level), 64'd0);
      mon_en = 1'b0;
      chk("s4_pop_count", 64'(pop_q.size()), 64'd5);
      for (int w = 0; w < 5; w++) begin
         for (int k = 0; k < 8; k++) exp_w[k*8 +: 8] = 8'(8*w + k + 1);
         if (w < pop_q.size()) chk($sformatf("s4_word%0d", w), pop_q[w], exp_w);
      end

      // Reset mid-word discards the partial word
      for (int i = 0; i < 5; i++) send1(8'(8'h91 + i), 1'b0);
      reset = 1'b1;
      tick();
      chk("s5_rst_q_ready", 64'(q_ready), 64'd0);
      chk("s5_rst_o_valid", 64'(o_valid), 64'd0);
      chk("s5_rst_o_data",  o_data, 64'd0);
      chk("s5_rst_o_keep",  64'(o_keep), 64'd0);
      chk("s5_rst_o_level", 64'(o_level), 64'd0);
`ifdef OT_QPACK_STAT_EN
      chk("s5_rst_stat_words", 64'(stat_words), 64'd0);
`endif
      reset = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) send1(8'(8'h21 + i), 1'b0);
      chk("s5_no_stale_commit", 64'(o_valid), 64'd0);
      send1(8'h28, 1'b0);
      chk("s5_valid", 64'(o_valid), 64'd1);
      chk("s5_data",  o_data, 64'h2827262524232221);
      chk("s5_keep",  64'(o_keep), 64'hFF);
      chk("s5_last",  64'(o_last), 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
